// File: rtl/password_lock.sv
// Password capture/confirm/unlock controller with failure counting and lockout.
// Every output is registered and settles one edge after the deciding press; key_pressed is never stalled, and presses in FAIL or LOCKOUT are dropped.
`timescale 1ns/1ps
module password_lock #(
    parameter int PASSWORD_LENGTH = 4,
    parameter int ERROR_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES  = 250_000_000,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 500_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] key_pressed,
    output logic       locked,
    output logic       error,
    output logic       lockout,
    output logic [3:0] digit_count,
    output logic [2:0] state_code
);

    localparam int CW = 2 * PASSWORD_LENGTH;
    localparam int EW = (ERROR_CYCLES > 1) ? $clog2(ERROR_CYCLES) : 1;
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FW = $clog2(MAX_ATTEMPTS + 1);
    localparam int HW = (EW > LW) ? EW : LW;

    typedef enum logic [2:0] {
        S_OPEN    = 3'd0,
        S_CONFIRM = 3'd1,
        S_SECURE  = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   entry;
    logic [CW-1:0]   candidate;
    logic [CW-1:0]   stored;
    logic [FW-1:0]   fail_count;
    logic            ret_secure;
    logic [TW-1:0]   idle_cnt;
    logic [HW-1:0]   hold_cnt;

    logic [1:0]      digit;
    logic            entry_state;
    logic            accept;
    logic            last;
    logic [CW-1:0]   next_entry;

    always_comb begin
        digit = 2'd0;
        case (key_pressed)
            4'b0010: digit = 2'd1;
            4'b0100: digit = 2'd2;
            4'b1000: digit = 2'd3;
            default: digit = 2'd0;
        endcase
    end

    assign entry_state = (state == S_OPEN) || (state == S_CONFIRM) || (state == S_SECURE);
    assign accept      = entry_state && $onehot(key_pressed);
    assign last        = accept && (digit_count == 4'(PASSWORD_LENGTH - 1));
    // Shifting through a wider concatenation keeps this valid for a one-digit code.
    assign next_entry  = CW'({entry, digit});
    assign state_code  = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_OPEN;
            entry       <= '0;
            candidate   <= '0;
            stored      <= '0;
            fail_count  <= '0;
            ret_secure  <= 1'b0;
            idle_cnt    <= '0;
            hold_cnt    <= '0;
            digit_count <= 4'd0;
            locked      <= 1'b0;
            error       <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            case (state)
                S_OPEN, S_CONFIRM, S_SECURE: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (last) begin
                            digit_count <= 4'd0;
                            entry       <= '0;
                            hold_cnt    <= '0;
                            if (state == S_OPEN) begin
                                candidate <= next_entry;
                                state     <= S_CONFIRM;
                            end else if (state == S_CONFIRM) begin
                                if (next_entry == candidate) begin
                                    stored <= candidate;
                                    state  <= S_SECURE;
                                    locked <= 1'b1;
                                end else begin
                                    ret_secure <= 1'b0;
                                    state      <= S_FAIL;
                                    error      <= 1'b1;
                                end
                            end else begin
                                if (next_entry == stored) begin
                                    fail_count <= '0;
                                    state      <= S_OPEN;
                                    locked     <= 1'b0;
                                end else begin
                                    if (fail_count < FW'(MAX_ATTEMPTS))
                                        fail_count <= fail_count + 1'b1;
                                    ret_secure <= 1'b1;
                                    state      <= S_FAIL;
                                    error      <= 1'b1;
                                end
                            end
                        end else begin
                            entry       <= next_entry;
                            digit_count <= digit_count + 4'd1;
                        end
                    end else if (digit_count != 4'd0) begin
                        // Idle edges, including illegal key patterns, advance the timer.
                        if (idle_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                            idle_cnt    <= '0;
                            digit_count <= 4'd0;
                            if (state == S_CONFIRM) begin
                                candidate <= '0;
                                state     <= S_OPEN;
                            end
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_FAIL: begin
                    if (hold_cnt >= HW'(ERROR_CYCLES - 1)) begin
                        hold_cnt <= '0;
                        error    <= 1'b0;
                        if (ret_secure && (fail_count >= FW'(MAX_ATTEMPTS))) begin
                            state   <= S_LOCKOUT;
                            lockout <= 1'b1;
                        end else if (ret_secure) begin
                            state <= S_SECURE;
                        end else begin
                            state <= S_OPEN;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (hold_cnt >= HW'(LOCKOUT_CYCLES - 1)) begin
                        hold_cnt   <= '0;
                        fail_count <= '0;
                        lockout    <= 1'b0;
                        state      <= S_SECURE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_OPEN;
                    locked  <= 1'b0;
                    error   <= 1'b0;
                    lockout <= 1'b0;
                end
            endcase
        end
    end

endmodule
